// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential binary to packed-BCD converter (shift-and-add-3),
//            one input bit per clock. Drives a seven-segment scanner, so the
//            published result is only updated when a conversion completes.
// Ports    : clk      - clock, rising edge active
//            rst      - asynchronous active-high reset
//            start    - conversion request, sampled only while idle
//            bin_in   - unsigned binary value, captured with start
//            busy     - high while a conversion is running
//            done     - one-cycle pulse when bcd_out/ovf were updated
//            bcd_out  - packed BCD result, digit 0 in [3:0]
//            ovf      - last captured value exceeded 10^DIGITS - 1
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int BIN_W  = 27,  // must cover 10^DIGITS - 1; at most 64
  parameter int DIGITS = 8    // 1..8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int C_BCD_W = 4 * DIGITS;
  localparam int C_CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] max_decimal(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  // Largest value representable in DIGITS decimal digits.
  localparam logic [63:0] C_MAX_DEC = max_decimal(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [BIN_W-1:0]     shift_q,   shift_d;
  logic [C_BCD_W-1:0]   scratch_q, scratch_d;
  logic [C_CNT_W-1:0]   cnt_q,     cnt_d;
  logic                 ovf_lat_q, ovf_lat_d;
  logic [C_BCD_W-1:0]   bcd_q,     bcd_d;
  logic                 ovf_q,     ovf_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;

  always_comb begin
    logic       carry;
    logic [3:0] dig;

    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_lat_d = ovf_lat_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    carry     = 1'b0;
    dig       = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = bin_in;
          scratch_d = '0;
          cnt_d     = C_CNT_W'(BIN_W);
          ovf_lat_d = (64'(bin_in) > C_MAX_DEC);
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // Add-3 then shift, fused per digit: each adjusted digit's MSB is
        // the bit that shifts into the next digit up. The top digit's MSB
        // falls off; range errors are reported by the overflow latch only.
        carry = shift_q[BIN_W-1];
        for (int i = 0; i < DIGITS; i++) begin
          dig = scratch_q[4*i +: 4];
          if (dig >= 4'd5) begin
            dig = dig + 4'd3;
          end
          scratch_d[4*i +: 4] = {dig[2:0], carry};
          carry               = dig[3];
        end
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d   = cnt_q - C_CNT_W'(1);
        if (cnt_q == C_CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        bcd_d   = ovf_lat_q ? {DIGITS{4'h9}} : scratch_q;
        ovf_d   = ovf_lat_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_lat_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_lat_q <= ovf_lat_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Self-checking bench for bin2bcd_seq with a transaction-level
//            reference model (decimal digits via division, fixed latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;
  localparam longint MAXD = 64'd99999999;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [BIN_W-1:0]  bin_in = '0;
  logic              busy;
  logic              done;
  logic [31:0]       bcd_out;
  logic              ovf;

  int tests = 0;
  int fails = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input longint v);
    logic [31:0] r;
    longint      x;
    r = '0;
    x = v;
    if (v > MAXD) return 32'h99999999;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference model: a conversion is accepted when idle, and its result
  // appears BIN_W+1 clocks later together with a one-cycle done.
  int          m_timer = 0;
  logic [31:0] m_pend_bcd = '0;
  logic        m_pend_ovf = 1'b0;
  logic [31:0] m_bcd = '0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_timer <= 0;
      m_bcd   <= '0;
      m_ovf   <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_timer > 0) begin
        m_timer <= m_timer - 1;
        if (m_timer == 1) begin
          m_bcd  <= m_pend_bcd;
          m_ovf  <= m_pend_ovf;
          m_done <= 1'b1;
        end
      end else if (start) begin
        m_pend_bcd <= ref_bcd(longint'(bin_in));
        m_pend_ovf <= (longint'(bin_in) > MAXD);
        m_timer    <= BIN_W + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_timer != 0);
    check("done", done, m_done);
    check("bcd_out", bcd_out, m_bcd);
    check("ovf", ovf, m_ovf);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input logic [BIN_W-1:0] v);
    start  = 1'b1;
    bin_in = v;
    step();
    start  = 1'b0;
    bin_in = BIN_W'($urandom);
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic convert(input logic [BIN_W-1:0] v, input logic [31:0] exp_bcd,
                         input logic exp_ovf, input string name);
    int lat, bc;
    start_conv(v);
    wait_done(lat, bc);
    check({name, "_latency"}, lat, 28);
    check({name, "_bcd"}, bcd_out, exp_bcd);
    check({name, "_ovf"}, ovf, exp_ovf);
    check({name, "_busy_low"}, busy, 1'b0);
    step();
  endtask

  initial begin
    int lat, bc, dcount;
    logic [BIN_W-1:0] v;

    repeat (3) step();
    check("rst_bcd", bcd_out, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    // Zero, with busy duration
    start_conv('0);
    wait_done(lat, bc);
    check("zero_latency", lat, 28);
    check("zero_busy_cycles", bc, 28);
    check("zero_bcd", bcd_out, 32'h0);
    check("zero_ovf", ovf, 1'b0);
    step();

    convert(27'd12345678, 32'h12345678, 1'b0, "v12345678");
    convert(27'd5,        32'h00000005, 1'b0, "v5");
    convert(27'd99999999, 32'h99999999, 1'b0, "v99999999");
    convert(27'd100000000, 32'h99999999, 1'b1, "v100000000");
    convert(27'd134217727, 32'h99999999, 1'b1, "vallones");

    // Asynchronous reset between edges while outputs are non-zero
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_bcd", bcd_out, 32'h0);
    check("arst_ovf", ovf, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    step();
    step();
    check("arst_hold_bcd", bcd_out, 32'h0);
    rst = 1'b0;

    // Hold during conversion and ignored start in SHIFT
    convert(27'd42, 32'h00000042, 1'b0, "v42");
    start_conv(27'd7);
    repeat (5) step();
    check("hold_bcd", bcd_out, 32'h00000042);
    start  = 1'b1;
    bin_in = 27'd999;
    step();
    start  = 1'b0;
    check("hold_busy", busy, 1'b1);
    wait_done(lat, bc);
    check("ignored_start_bcd", bcd_out, 32'h00000007);

    // Start accepted in the done cycle
    start_conv(27'd31415926);
    wait_done(lat, bc);
    check("b2b_latency", lat, 28);
    check("b2b_bcd", bcd_out, 32'h31415926);
    step();

    // Reset mid-conversion
    convert(27'd12345678, 32'h12345678, 1'b0, "pre_abort");
    start_conv(27'd12345678);
    repeat (9) step();
    #2;
    rst = 1'b1;
    #1;
    check("abort_bcd", bcd_out, 32'h0);
    step();
    step();
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      step();
    end
    check("abort_no_done", dcount, 0);
    convert(27'd55, 32'h00000055, 1'b0, "v55");

    // Random conversions with random gaps
    for (int n = 0; n < 20; n++) begin
      if (n % 3 == 0) v = BIN_W'($urandom_range(134217727, 0));
      else            v = BIN_W'($urandom_range(99999999, 0));
      start_conv(v);
      wait_done(lat, bc);
      check("rand_latency", lat, 28);
      check("rand_bcd", bcd_out, ref_bcd(longint'(v)));
      repeat ($urandom_range(3, 0)) step();
    end

    // Start held high with a changing bin_in
    start = 1'b1;
    for (int i = 0; i < 3 * (BIN_W + 2); i++) begin
      bin_in = BIN_W'($urandom);
      step();
    end
    start = 1'b0;
    repeat (BIN_W + 4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
